fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the instruction decoder.
- Holds the PC and drives the instruction-memory address. Latches the fetched 16-bit instruction with its PC into the IF/ID register for decode.
- Applies redirects: taken branches from execute, and JMP/CALL/RET targets from decode. Handles stall and bubble insertion.

---
 rtl/fetch_stage.sv | 68 ++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// The PC drives the asynchronous-read instruction memory directly.
// The word that comes back is latched with its PC into IF/ID for decode.
// Redirect priority, highest first:
//   reset, then execute branch, then stall, then decode jump, then sequential fetch.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        jmp_valid,
  input  logic [15:0] jmp_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] currentPC,
  output logic [15:0] next_pc,
  output logic        if_valid,
  output logic [15:0] fetch_count
);

  logic [15:0] pc;
  logic [15:0] pc_inc;

  // Sequential successor; 16-bit arithmetic wraps 16'hFFFF to 16'h0000
  assign pc_inc    = pc + 16'h0001;
  assign imem_addr = pc;

  // PC and IF/ID update.
  // A bubble leaves currentPC and next_pc untouched, so only the valid flag marks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      currentPC   <= 16'h0000;
      next_pc     <= 16'h0000;
      if_valid    <= 1'b0;
      fetch_count <= 16'h0000;
    end else if (br_taken) begin
      // The branch is older than anything being stalled or jumped in decode
      pc          <= br_target;
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
    end else if (stall) begin
      // Hold everything; decode re-asserts any pending jump after the stall clears
      pc          <= pc;
    end else if (jmp_valid) begin
      // Squash the word fetched this cycle: one-cycle jump penalty
      pc          <= jmp_target;
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
    end else begin
      pc          <= pc_inc;
      instruction <= imem_data;
      currentPC   <= pc;
      next_pc     <= pc_inc;
      if_valid    <= 1'b1;
      if (fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// The reference model tracks the architectural state per cycle using plain integer arithmetic.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'hE00E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        jmp_valid = 1'b0;
  logic [15:0] jmp_target = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] currentPC;
  logic [15:0] next_pc;
  logic        if_valid;
  logic [15:0] fetch_count;

  logic [15:0] key = 16'h0000;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_pc;
  int m_instr;
  int m_cpc;
  int m_npc;
  int m_valid;
  int m_cnt;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .currentPC(currentPC), .next_pc(next_pc),
    .if_valid(if_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory contents: 16'h1000 + address, optionally scrambled by key
  assign imem_data = (imem_addr + 16'h1000) ^ key;

  function automatic int mem_word(input int a);
    return ((a + 'h1000) % 65536) ^ int'(key);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_imem_addr"},   imem_addr,   16'(m_pc));
    chk({tag, "_instruction"}, instruction, 16'(m_instr));
    chk({tag, "_currentPC"},   currentPC,   16'(m_cpc));
    chk({tag, "_next_pc"},     next_pc,     16'(m_npc));
    chk({tag, "_if_valid"},    {15'd0, if_valid}, 16'(m_valid));
    chk({tag, "_fetch_count"}, fetch_count, 16'(m_cnt));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, sample 1 time unit later
  task automatic step(input bit r, input bit st, input bit bt, input logic [15:0] bta,
                      input bit jv, input logic [15:0] jta, input bit do_chk, input string tag);
    rst = r; stall = st; br_taken = bt; br_target = bta; jmp_valid = jv; jmp_target = jta;
    @(posedge clk);
    if (r) begin
      m_pc = int'(RST_PC); m_instr = int'(NOP); m_cpc = 0; m_npc = 0; m_valid = 0; m_cnt = 0;
    end else if (bt) begin
      m_pc = int'(bta); m_instr = int'(NOP); m_valid = 0;
    end else if (st) begin
      // nothing changes
    end else if (jv) begin
      m_pc = int'(jta); m_instr = int'(NOP); m_valid = 0;
    end else begin
      m_instr = mem_word(m_pc);
      m_cpc   = m_pc;
      m_npc   = (m_pc + 1) % 65536;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 65536;
      m_cnt   = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    end
    #1;
    if (do_chk) check_all(tag);
  endtask

  task automatic run(input string tag);
    step(0, 0, 0, 16'h0, 0, 16'h0, 1, tag);
  endtask

  initial begin
    logic [15:0] t;
    logic [15:0] held;
    bit r, st, bt, jv;
    logic [15:0] bta, jta;

    m_pc = 0; m_instr = 0; m_cpc = 0; m_npc = 0; m_valid = 0; m_cnt = 0;

    // Reset for two cycles
    step(1, 0, 0, 16'h0, 0, 16'h0, 1, "rst0");
    step(1, 0, 0, 16'h0, 0, 16'h0, 1, "rst1");

    // Sequential run
    run("run0");
    chk("run0_const_instr", instruction, 16'h1000);
    chk("run0_const_npc", next_pc, 16'h0001);
    run("run1");
    chk("run1_const_instr", instruction, 16'h1001);
    run("run2");
    run("run3");
    chk("pre_stall_instr", instruction, 16'h1003);
    chk("pre_stall_pc", imem_addr, 16'h0004);

    // Stall three cycles; a jump request under stall is ignored
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, (i == 1), 16'h0BAD, 1, "stall");
    chk("stall_hold_count", fetch_count, 16'd4);
    run("resume");
    chk("resume_instr", instruction, 16'h1004);
    run("run5");
    chk("pre_jmp_pc", imem_addr, 16'h0006);

    // Jump
    step(0, 0, 0, 16'h0, 1, 16'h0040, 1, "jmp");
    chk("jmp_addr", imem_addr, 16'h0040);
    chk("jmp_bubble", instruction, NOP);
    run("jmp_after");
    chk("jmp_after_cpc", currentPC, 16'h0040);

    // Branch beats stall and jump in the same cycle
    step(0, 1, 1, 16'h0100, 1, 16'h0200, 1, "br_all");
    chk("br_all_pc", imem_addr, 16'h0100);
    run("br_after");
    chk("br_after_cpc", currentPC, 16'h0100);

    // Redirect target equal to current pc
    t = imem_addr;
    step(0, 0, 0, 16'h0, 1, t, 1, "jmp_self");
    run("jmp_self_after");

    // Wrap through 16'hFFFF
    step(0, 0, 1, 16'hFFFF, 0, 16'h0, 1, "wrap_br");
    run("wrap0");
    chk("wrap0_cpc", currentPC, 16'hFFFF);
    chk("wrap0_npc", next_pc, 16'h0000);
    run("wrap1");
    chk("wrap1_cpc", currentPC, 16'h0000);

    // Reset beats branch
    step(1, 1, 1, 16'h0300, 1, 16'h0400, 1, "rst_br");
    chk("rst_br_pc", imem_addr, RST_PC);
    run("rst_br_after");

    // Randomized traffic with scrambled memory
    key = 16'h5A3C;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(99) < 2);
      bt = ($urandom_range(99) < 10);
      st = ($urandom_range(99) < 20);
      jv = ($urandom_range(99) < 15);
      case ($urandom_range(3))
        0: bta = 16'(m_pc);
        1: bta = 16'hFFFE + 16'($urandom_range(1));
        default: bta = 16'($urandom);
      endcase
      jta = ($urandom_range(3) == 0) ? 16'(m_pc) : 16'($urandom);
      step(r, st, bt, bta, jv, jta, 1, "rand");
    end

    // Saturation of fetch_count
    key = 16'h0000;
    step(1, 0, 0, 16'h0, 0, 16'h0, 1, "sat_rst");
    for (int i = 0; i < 65534; i++) step(0, 0, 0, 16'h0, 0, 16'h0, 0, "sat");
    check_all("sat_fffe");
    chk("sat_fffe_const", fetch_count, 16'hFFFE);
    run("sat_ffff");
    chk("sat_ffff_const", fetch_count, 16'hFFFF);
    run("sat_hold0");
    run("sat_hold1");
    chk("sat_hold_const", fetch_count, 16'hFFFF);
    step(0, 1, 0, 16'h0, 0, 16'h0, 1, "sat_stall");
    step(0, 0, 1, 16'h0010, 0, 16'h0, 1, "sat_br");
    run("sat_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
